// File: rtl/seg7_pkg.sv
// seg7_pkg: constants and types shared by the 4-digit seven-segment scanner
// and its decoder.
//   scan_state_t - slot phase: BLANK (all off) then DRIVE (one digit lit)
//   SEG_BLANK    - all segments off (active-low)
//   SEG_INVALID  - pattern shown for non-BCD nibbles 10..15
//   ANODE_OFF    - all digit anodes off (active-low)
package seg7_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [6:0] SEG_INVALID = 7'b0101010;
  localparam logic [3:0] ANODE_OFF   = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to seven-segment decoder.
// Ports:
//   bcd - 4-bit digit value (0..9 valid)
//   seg - segments gfedcba, active-low; 10..15 show SEG_INVALID
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_INVALID;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for a 4-digit common-anode display.
// Each digit gets a slot of REFRESH_DIV cycles: BLANK_CYC all-off cycles
// (ghosting guard) followed by the lit DRIVE phase. Four slots form a frame.
// New values are staged by load and only copied to the display register at a
// frame boundary, so a frame never mixes old and new digits.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - output enable (scan keeps running when low)
//   value_in   - four BCD nibbles, nibble i drives digit i
//   dp_in      - decimal point request per digit, active-high
//   load       - strobe staging value_in/dp_in
//   load_ack   - pulse when a staged value is copied to the display
//   frame_tick - pulse at each frame boundary
//   an, seg7, dp - active-low anode, segment and decimal point drives
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg7,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

  scan_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    digit_reg, digit_next;
  logic          frame_end;

  logic [15:0]   stage_val_reg, disp_val_reg, disp_val_next;
  logic [3:0]    stage_dp_reg, disp_dp_reg, disp_dp_next;
  logic          pending_reg;
  logic          swap;

  logic          show;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  logic [3:0]    an_reg;
  logic [6:0]    seg7_reg;
  logic          dp_reg;
  logic          load_ack_reg;
  logic          frame_tick_reg;

  // Slot sequencing; the counter runs across the whole slot and only clears
  // when DRIVE hands back to BLANK for the next digit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    digit_next = digit_reg;
    frame_end  = 1'b0;
    case (state_reg)
      BLANK: begin
        if (cnt_reg == BLANK_LAST) state_next = DRIVE;
      end
      DRIVE: begin
        if (cnt_reg == SLOT_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          digit_next = digit_reg + 2'd1;
          frame_end  = (digit_reg == 2'd3);
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  // The boundary always copies what was staged before this cycle; a load on
  // the same cycle lands in staging and waits for the next boundary.
  assign swap          = frame_end && pending_reg;
  assign disp_val_next = swap ? stage_val_reg : disp_val_reg;
  assign disp_dp_next  = swap ? stage_dp_reg  : disp_dp_reg;

  // Outputs are decoded from next-state values so they switch on the same
  // edge as the state/digit registers.
  assign show   = (state_next == DRIVE) && en;
  assign nibble = disp_val_next[{digit_next, 2'b00} +: 4];

  seg7_decode u_decode (
    .bcd (nibble),
    .seg (seg_dec)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_anode
    assign an_next[gi] = ~(show && (digit_next == 2'(gi)));
  end

  assign seg_next = show ? seg_dec : SEG_BLANK;
  assign dp_next  = show ? ~disp_dp_next[digit_next] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= BLANK;
      cnt_reg        <= '0;
      digit_reg      <= 2'd0;
      stage_val_reg  <= 16'h0000;
      stage_dp_reg   <= 4'h0;
      disp_val_reg   <= 16'h0000;
      disp_dp_reg    <= 4'h0;
      pending_reg    <= 1'b0;
      load_ack_reg   <= 1'b0;
      frame_tick_reg <= 1'b0;
      an_reg         <= ANODE_OFF;
      seg7_reg       <= SEG_BLANK;
      dp_reg         <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      digit_reg    <= digit_next;
      disp_val_reg <= disp_val_next;
      disp_dp_reg  <= disp_dp_next;
      if (load) begin
        stage_val_reg <= value_in;
        stage_dp_reg  <= dp_in;
        pending_reg   <= 1'b1;
      end else if (frame_end) begin
        pending_reg <= 1'b0;
      end
      load_ack_reg   <= swap;
      frame_tick_reg <= frame_end;
      an_reg         <= an_next;
      seg7_reg       <= seg_next;
      dp_reg         <= dp_next;
    end
  end

  assign an         = an_reg;
  assign seg7       = seg7_reg;
  assign dp         = dp_reg;
  assign load_ack   = load_ack_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl with REFRESH_DIV=8,
// BLANK_CYC=2 (8-cycle slots, 32-cycle frames). A frame-position model
// predicts every cycle's outputs when stimulus is driven; each scenario task
// pops and compares after the clock edge.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load_ack, frame_tick, dp;
  logic [3:0]  an;
  logic [6:0]  seg7;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .an         (an),
    .seg7       (seg7),
    .dp         (dp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // expected {an, seg7, dp, frame_tick, load_ack}
  logic [13:0] exp_q[$];

  // model: m_pos is the position (0..31) within the frame of the current cycle
  int          m_pos = 0;
  logic        m_pending = 1'b0;
  logic [15:0] m_stage_v = '0, m_disp_v = '0;
  logic [3:0]  m_stage_dp = '0, m_disp_dp = '0;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0101010;
    endcase
  endfunction

  // Drive one cycle of stimulus, predict the outputs after the edge, push
  // the prediction, and return at the following negedge.
  task automatic drive_cycle(input logic r, input logic e, input logic ld,
                             input logic [15:0] v, input logic [3:0] d);
    logic [3:0] a;
    logic [6:0] s;
    logic       p, ft, ak;
    int         slot, dig;
    rst = r; en = e; load = ld; value_in = v; dp_in = d;
    a = 4'b1111; s = 7'b1111111; p = 1'b1; ft = 1'b0; ak = 1'b0;
    if (r) begin
      m_pos = 0; m_pending = 1'b0;
      m_stage_v = '0; m_stage_dp = '0; m_disp_v = '0; m_disp_dp = '0;
    end else begin
      if (m_pos == 31) begin
        ft = 1'b1;
        if (m_pending) begin
          m_disp_v = m_stage_v; m_disp_dp = m_stage_dp;
          m_pending = 1'b0; ak = 1'b1;
        end
      end
      if (ld) begin
        m_stage_v = v; m_stage_dp = d; m_pending = 1'b1;
      end
      m_pos = (m_pos + 1) % 32;
      slot = m_pos % 8;
      dig  = m_pos / 8;
      if (slot >= 2 && e) begin
        a[dig] = 1'b0;
        s = ref_seg(m_disp_v[dig*4 +: 4]);
        p = ~m_disp_dp[dig];
      end
    end
    exp_q.push_back({a, s, p, ft, ak});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [13:0] got, want;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 16'h8888, 4'hF);
      got = {an, seg7, dp, frame_tick, load_ack}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset cyc %0d: an_seg_dp_ft_ack got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_scan();
    logic [13:0] got, want;
    int ticks = 0;
    for (int i = 0; i < 70; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);
      got = {an, seg7, dp, frame_tick, load_ack}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL scan cyc %0d: an_seg_dp_ft_ack got %b want %b", i, got, want);
      end
      if (frame_tick) ticks++;
    end
    // positions 1..70 contain boundaries at 32 and 64
    n_checks++;
    if (ticks != 2) begin
      n_fail++;
      $display("FAIL scan_tick_count: got %0d want 2", ticks);
    end
  endtask

  task automatic test_load_mid_frame();
    logic [13:0] got, want;
    int acks = 0;
    logic ld;
    logic done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ld = !done && (m_pos == 12);
      if (ld) done = 1'b1;
      drive_cycle(1'b0, 1'b1, ld, 16'h4321, 4'b0100);
      got = {an, seg7, dp, frame_tick, load_ack}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_mid_frame cyc %0d: an_seg_dp_ft_ack got %b want %b", i, got, want);
      end
      if (load_ack) begin
        acks++;
        n_checks++;
        if (frame_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL load_ack_with_tick: frame_tick got %b want 1", frame_tick);
        end
      end
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL load_mid_frame_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] got, want;
    int acks = 0;
    int nl = 0;
    logic ld;
    logic [15:0] v;
    for (int i = 0; i < 90; i++) begin
      ld = 1'b0; v = 16'h1111;
      if (nl == 0 && m_pos == 3)       begin ld = 1'b1; nl = 1; end
      else if (nl == 1 && m_pos == 10) begin ld = 1'b1; v = 16'h9999; nl = 2; end
      drive_cycle(1'b0, 1'b1, ld, v, 4'b0000);
      got = {an, seg7, dp, frame_tick, load_ack}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: an_seg_dp_ft_ack got %b want %b", i, got, want);
      end
      if (load_ack) acks++;
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL back_to_back_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_load_at_boundary();
    logic [13:0] got, want;
    int nl = 0;
    logic ld;
    logic [15:0] v;
    for (int i = 0; i < 140; i++) begin
      ld = 1'b0; v = 16'h0000;
      // 5555 on the frame_tick cycle
      if (nl == 0 && m_pos == 0 && i > 0) begin ld = 1'b1; v = 16'h5555; nl = 1; end
      // 0123 pending, then 8888 on the boundary decode cycle itself
      else if (nl == 1 && m_pos == 5 && i > 40) begin ld = 1'b1; v = 16'h0123; nl = 2; end
      else if (nl == 2 && m_pos == 31) begin ld = 1'b1; v = 16'h8888; nl = 3; end
      drive_cycle(1'b0, 1'b1, ld, v, 4'b1001);
      got = {an, seg7, dp, frame_tick, load_ack}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_at_boundary cyc %0d: an_seg_dp_ft_ack got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_invalid_and_en();
    logic [13:0] got, want;
    int ticks = 0;
    logic ld, e;
    logic done = 1'b0;
    for (int i = 0; i < 128; i++) begin
      ld = !done && (m_pos == 4);
      if (ld) done = 1'b1;
      e = !(i > 40 && m_pos >= 12 && m_pos <= 20);
      drive_cycle(1'b0, e, ld, 16'hFEDA, 4'b0010);
      got = {an, seg7, dp, frame_tick, load_ack}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL invalid_en cyc %0d: an_seg_dp_ft_ack got %b want %b", i, got, want);
      end
      if (!e) begin
        n_checks++;
        if (an !== 4'b1111) begin
          n_fail++;
          $display("FAIL en_low_anodes cyc %0d: got %b want 1111", i, an);
        end
      end
      if (frame_tick) ticks++;
    end
    n_checks++;
    if (ticks != 4) begin
      n_fail++;
      $display("FAIL en_tick_cadence: got %0d want 4", ticks);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] got, want;
    int acks = 0;
    int ph = 0;
    logic ld, r;
    for (int i = 0; i < 90; i++) begin
      ld = 1'b0; r = 1'b0;
      if (ph == 0 && m_pos == 18) begin ld = 1'b1; ph = 1; end
      else if (ph == 1 && m_pos == 21) begin r = 1'b1; ph = 2; end
      else if (ph == 2) begin r = 1'b1; ph = 3; end
      drive_cycle(r, 1'b1, ld, 16'h7777, 4'hF);
      got = {an, seg7, dp, frame_tick, load_ack}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: an_seg_dp_ft_ack got %b want %b", i, got, want);
      end
      if (ph == 3 && load_ack) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL reset_mid_acks: got %0d want 0", acks);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_back_to_back();
    test_load_at_boundary();
    test_invalid_and_en();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
